// File: rtl/dircc_packet_rx.sv
// ----------------------------------------------------------------------------
// dircc_packet_rx
//
// Store-and-forward Avalon-ST packet receiver for one DiRCC node output port.
// Beats are framed with sop/eop/empty and written into a circular word
// buffer. A packet becomes visible to the reader only once its eop beat has
// been written (commit). Beats arriving without a sop, packets that restart
// before their eop, and packets longer than DEPTH are discarded and counted.
//
// Ports
//   clk_clk, reset_reset          clock, asynchronous active-high reset
//   input_*                       Avalon-ST sink (data/valid/ready/sop/eop/empty)
//   output_*                      Avalon-ST source (data/valid/ready/sop/eop/empty)
//   packets_pending               committed packets whose eop has not been read
//   drop_count                    discarded-packet counter, saturating at 255
// ----------------------------------------------------------------------------
module dircc_packet_rx #(
    parameter int DATA_WIDTH  = 32,
    parameter int EMPTY_WIDTH = 2,
    parameter int DEPTH       = 16,
    parameter int AW          = $clog2(DEPTH)
) (
    input  logic                   clk_clk,
    input  logic                   reset_reset,
    input  logic [DATA_WIDTH-1:0]  input_data,
    input  logic                   input_valid,
    output logic                   input_ready,
    input  logic                   input_startofpacket,
    input  logic                   input_endofpacket,
    input  logic [EMPTY_WIDTH-1:0] input_empty,
    output logic [DATA_WIDTH-1:0]  output_data,
    output logic                   output_valid,
    input  logic                   output_ready,
    output logic                   output_startofpacket,
    output logic                   output_endofpacket,
    output logic [EMPTY_WIDTH-1:0] output_empty,
    output logic [AW:0]            packets_pending,
    output logic [7:0]             drop_count
);

    typedef struct packed {
        logic                   sop;
        logic                   eop;
        logic [EMPTY_WIDTH-1:0] empty;
        logic [DATA_WIDTH-1:0]  data;
    } entry_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RECV,
        ST_DROP
    } wr_state_e;

    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    entry_t      mem_q [DEPTH];
    wr_state_e   state_q, state_d;
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] commit_ptr_q, commit_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0] pending_q;
    logic [7:0]  drop_q;

    logic [AW:0] used;
    logic [AW:0] partial_inc;
    logic [AW:0] wr_addr;
    logic        full;
    logic        accept;
    logic        wr_en;
    logic        start;
    logic        commit;
    logic        drop_inc;
    logic        rd_fire;
    entry_t      in_entry;
    entry_t      rd_entry;

    // Occupancy comes from registered pointers only; no same-cycle bypass.
    assign used        = wr_ptr_q - rd_ptr_q;
    assign full        = (used == FULL_LVL);
    // Length the open packet would reach if the current beat is written.
    assign partial_inc = wr_ptr_q + 1'b1 - commit_ptr_q;

    // DROP swallows beats without storing them, so it never backpressures.
    assign input_ready = (state_q == ST_DROP) || !full;
    assign accept      = input_valid && input_ready;
    assign in_entry    = {input_startofpacket, input_endofpacket, input_empty, input_data};

    // ------------------------------------------------------------------
    // Write-side FSM: next state, pointer updates and buffer write enable
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        wr_addr      = wr_ptr_q;
        wr_en        = 1'b0;
        start        = 1'b0;
        commit       = 1'b0;
        drop_inc     = 1'b0;

        if (accept) begin
            case (state_q)
                ST_IDLE: begin
                    if (input_startofpacket) start    = 1'b1;
                    else                     drop_inc = 1'b1;   // stray beat
                end
                ST_RECV: begin
                    if (input_startofpacket) begin
                        // Missing eop: abandon the open packet, restart here.
                        drop_inc = 1'b1;
                        start    = 1'b1;
                    end else begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        if (input_endofpacket) begin
                            commit_ptr_d = wr_ptr_q + 1'b1;
                            commit       = 1'b1;
                            state_d      = ST_IDLE;
                        end else if (partial_inc == FULL_LVL) begin
                            // Oversize: the word lands in a slot that is
                            // immediately released by the rewind.
                            wr_ptr_d = commit_ptr_q;
                            drop_inc = 1'b1;
                            state_d  = ST_DROP;
                        end
                    end
                end
                ST_DROP: begin
                    // A restart needs a free slot; without one the sop beat
                    // is swallowed along with the rest of that packet.
                    if (input_startofpacket && !full) start   = 1'b1;
                    else if (input_endofpacket)       state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase

            // A new packet always begins at commit_ptr, which also discards
            // any partial packet still sitting in the buffer.
            if (start) begin
                wr_en    = 1'b1;
                wr_addr  = commit_ptr_q;
                wr_ptr_d = commit_ptr_q + 1'b1;
                if (input_endofpacket) begin
                    commit_ptr_d = commit_ptr_q + 1'b1;
                    commit       = 1'b1;
                    state_d      = ST_IDLE;
                end else begin
                    state_d = ST_RECV;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read side: only committed words are visible
    // ------------------------------------------------------------------
    assign rd_entry     = mem_q[rd_ptr_q[AW-1:0]];
    assign output_valid = (rd_ptr_q != commit_ptr_q);
    assign rd_fire      = output_valid && output_ready;
    assign rd_ptr_d     = rd_ptr_q + {{AW{1'b0}}, rd_fire};

    // Buffer contents are undefined after reset, so fields are gated.
    assign output_data          = output_valid ? rd_entry.data  : '0;
    assign output_startofpacket = output_valid && rd_entry.sop;
    assign output_endofpacket   = output_valid && rd_entry.eop;
    assign output_empty         = output_valid ? rd_entry.empty : '0;

    assign packets_pending = pending_q;
    assign drop_count      = drop_q;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            pending_q    <= '0;
            drop_q       <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;

            case ({commit, rd_fire && rd_entry.eop})
                2'b10:   pending_q <= pending_q + 1'b1;
                2'b01:   pending_q <= pending_q - 1'b1;
                default: pending_q <= pending_q;
            endcase

            if (drop_inc && (drop_q != 8'hFF)) drop_q <= drop_q + 1'b1;
        end
    end

    // NOTE: the word buffer is deliberately not reset; pointers define which
    // entries are meaningful, and leaving it out lets it map onto RAM.
    always_ff @(posedge clk_clk) begin
        if (wr_en) mem_q[wr_addr[AW-1:0]] <= in_entry;
    end

endmodule

// File: tb/tb_dircc_packet_rx.sv
// ----------------------------------------------------------------------------
// tb_dircc_packet_rx
//
// Directed and randomized stimulus against a packet-level reference model:
// the model keeps a queue of committed beats awaiting the reader, the list of
// beats of the packet being received, and a drop counter. Every cycle the
// DUT outputs are compared with what that model predicts.
// ----------------------------------------------------------------------------
module tb_dircc_packet_rx;

    localparam int DW    = 32;
    localparam int EW    = 2;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    typedef struct packed {
        logic          sop;
        logic          eop;
        logic [EW-1:0] empty;
        logic [DW-1:0] data;
    } beat_t;

    logic          clk_clk = 1'b0;
    logic          reset_reset;
    logic [DW-1:0] input_data;
    logic          input_valid;
    logic          input_ready;
    logic          input_startofpacket;
    logic          input_endofpacket;
    logic [EW-1:0] input_empty;
    logic [DW-1:0] output_data;
    logic          output_valid;
    logic          output_ready;
    logic          output_startofpacket;
    logic          output_endofpacket;
    logic [EW-1:0] output_empty;
    logic [AW:0]   packets_pending;
    logic [7:0]    drop_count;

    always #5 clk_clk = ~clk_clk;

    dircc_packet_rx #(
        .DATA_WIDTH (DW),
        .EMPTY_WIDTH(EW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk_clk             (clk_clk),
        .reset_reset         (reset_reset),
        .input_data          (input_data),
        .input_valid         (input_valid),
        .input_ready         (input_ready),
        .input_startofpacket (input_startofpacket),
        .input_endofpacket   (input_endofpacket),
        .input_empty         (input_empty),
        .output_data         (output_data),
        .output_valid        (output_valid),
        .output_ready        (output_ready),
        .output_startofpacket(output_startofpacket),
        .output_endofpacket  (output_endofpacket),
        .output_empty        (output_empty),
        .packets_pending     (packets_pending),
        .drop_count          (drop_count)
    );

    // Reference model state
    beat_t outq[$];      // committed beats not yet read
    beat_t partial[$];   // beats of the packet currently being received
    bit    in_pkt;
    bit    dropping;
    int    drops;

    int    total = 0;
    int    bad   = 0;
    bit    rand_oready   = 1'b0;
    int    release_after = -1;
    bit    saw_stall     = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int pending_exp();
        int n = 0;
        foreach (outq[i]) if (outq[i].eop) n++;
        return n;
    endfunction

    function automatic void model_reset();
        outq.delete();
        partial.delete();
        in_pkt   = 1'b0;
        dropping = 1'b0;
        drops    = 0;
    endfunction

    function automatic void count_drop();
        if (drops < 255) drops++;
    endfunction

    function automatic void commit_pkt();
        foreach (partial[i]) outq.push_back(partial[i]);
        partial.delete();
        in_pkt = 1'b0;
    endfunction

    // Packet-level receive rules; 'room' is whether the buffer had a free
    // slot before this edge.
    function automatic void model_beat(input beat_t b, input bit room);
        if (b.sop) begin
            if (dropping && !room) begin
                if (b.eop) dropping = 1'b0;
            end else begin
                if (in_pkt) count_drop();
                partial.delete();
                partial.push_back(b);
                in_pkt   = 1'b1;
                dropping = 1'b0;
                if (b.eop) commit_pkt();
            end
        end else if (dropping) begin
            if (b.eop) dropping = 1'b0;
        end else if (!in_pkt) begin
            count_drop();
        end else begin
            partial.push_back(b);
            if (b.eop) begin
                commit_pkt();
            end else if (partial.size() == DEPTH) begin
                count_drop();
                partial.delete();
                in_pkt   = 1'b0;
                dropping = 1'b1;
            end
        end
    endfunction

    // One clock cycle: compare outputs with the model, cross the edge, update.
    task automatic cycle(output bit accepted);
        bit    rdy_exp;
        bit    ov_exp;
        bit    fire;
        bit    room;
        beat_t h;
        if (rand_oready) output_ready = 1'($urandom_range(0, 1));
        room    = (outq.size() + partial.size()) < DEPTH;
        rdy_exp = dropping || room;
        ov_exp  = outq.size() != 0;
        h       = ov_exp ? outq[0] : '0;
        check("input_ready",     input_ready,          rdy_exp);
        check("output_valid",    output_valid,         ov_exp);
        check("output_data",     output_data,          h.data);
        check("output_sop",      output_startofpacket, h.sop);
        check("output_eop",      output_endofpacket,   h.eop);
        check("output_empty",    output_empty,         h.empty);
        check("packets_pending", packets_pending,      pending_exp());
        check("drop_count",      drop_count,           drops);
        accepted = input_valid && rdy_exp;
        fire     = ov_exp && output_ready;
        @(posedge clk_clk);
        if (fire) void'(outq.pop_front());
        if (accepted)
            model_beat({input_startofpacket, input_endofpacket, input_empty, input_data}, room);
        #1;
    endtask

    task automatic idle(input int n);
        bit acc;
        input_valid = 1'b0;
        repeat (n) cycle(acc);
    endtask

    task automatic send_beat(input bit sop, input bit eop, input logic [EW-1:0] emp,
                             input logic [DW-1:0] data, input int gap);
        bit acc = 1'b0;
        int stalls = 0;
        input_valid         = 1'b1;
        input_startofpacket = sop;
        input_endofpacket   = eop;
        input_empty         = emp;
        input_data          = data;
        while (!acc && stalls < 300) begin
            cycle(acc);
            if (!acc) begin
                stalls++;
                saw_stall = 1'b1;
                if (stalls == release_after) output_ready = 1'b1;
            end
        end
        if (!acc) check("accept_timeout", 64'd0, 64'd1);
        input_valid = 1'b0;
        if (gap > 0) idle(gap);
    endtask

    // base != 0 gives data base*(i+1); base == 0 gives random data.
    task automatic send_packet(input int n, input bit with_eop, input logic [EW-1:0] emp,
                               input logic [DW-1:0] base, input int gap_max);
        for (int i = 0; i < n; i++)
            send_beat(i == 0, with_eop && (i == n - 1), emp,
                      (base != 0) ? base * DW'(i + 1) : $urandom,
                      $urandom_range(0, gap_max));
    endtask

    task automatic drain();
        int n = 0;
        rand_oready  = 1'b0;
        output_ready = 1'b1;
        input_valid  = 1'b0;
        while (outq.size() != 0 && n < 400) begin
            idle(1);
            n++;
        end
        if (outq.size() != 0) check("drain_timeout", 64'd0, 64'd1);
        idle(2);
    endtask

    initial begin
        reset_reset         = 1'b1;
        input_valid         = 1'b0;
        input_startofpacket = 1'b0;
        input_endofpacket   = 1'b0;
        input_empty         = '0;
        input_data          = '0;
        output_ready        = 1'b1;
        model_reset();
        repeat (3) @(posedge clk_clk);
        #1;
        check("reset_output_valid", output_valid, 1'b0);
        check("reset_input_ready",  input_ready,  1'b1);
        check("reset_pending",      packets_pending, 0);
        check("reset_drop_count",   drop_count,   0);
        reset_reset = 1'b0;
        idle(2);

        // 4-word packet, empty=2 on every beat, reader always ready
        send_packet(4, 1'b1, 2'd2, 32'h11, 0);
        drain();

        // Single-beat packet
        send_beat(1'b1, 1'b1, 2'd0, 32'hCAFE, 0);
        drain();
        check("single_beat_drops", drop_count, 0);

        // Stray beat without sop, then a 2-word packet
        send_beat(1'b0, 1'b0, 2'd0, 32'hDEAD, 1);
        send_packet(2, 1'b1, 2'd1, 32'h100, 1);
        drain();
        check("stray_drops", drop_count, 1);

        // 5 words then a new sop before eop; second packet kept
        send_packet(5, 1'b0, 2'd0, 32'h200, 0);
        send_packet(3, 1'b1, 2'd3, 32'h300, 0);
        drain();
        check("restart_drops", drop_count, 2);

        // 20-word packet: oversize, discarded without backpressure
        send_packet(20, 1'b1, 2'd0, 32'h400, 0);
        drain();
        check("oversize_drops", drop_count, 3);

        // Slow reader: three 6-word packets, reader released once stalled
        output_ready  = 1'b0;
        saw_stall     = 1'b0;
        release_after = 4;
        for (int p = 0; p < 3; p++) send_packet(6, 1'b1, 2'd1, 32'h1000 * (p + 1), 0);
        release_after = -1;
        check("backpressure_seen", saw_stall, 1'b1);
        drain();
        check("backpressure_drops", drop_count, 3);

        // Randomized traffic with random reader readiness and framing errors
        rand_oready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            int kind = $urandom_range(0, 9);
            if (kind == 0)      send_beat(1'b0, 1'($urandom_range(0, 1)), 2'd0, $urandom, 1);
            else if (kind == 1) send_packet($urandom_range(1, 8), 1'b0, 2'($urandom), 0, 2);
            else                send_packet($urandom_range(1, 20), 1'b1, 2'($urandom), 0, 2);
        end
        drain();

        // Reset in the middle of a packet: partial packet lost, no drop
        send_packet(3, 1'b0, 2'd0, 32'h500, 0);
        #2 reset_reset = 1'b1;
        #1;
        check("midreset_output_valid", output_valid, 1'b0);
        check("midreset_drop_count",   drop_count,   0);
        check("midreset_input_ready",  input_ready,  1'b1);
        model_reset();
        @(posedge clk_clk);
        #1 reset_reset = 1'b0;
        idle(1);
        send_packet(2, 1'b1, 2'd2, 32'h600, 0);
        drain();
        check("after_reset_drops", drop_count, 0);

        // Drop counter saturation
        for (int k = 0; k < 260; k++) send_beat(1'b0, 1'b0, 2'd0, $urandom, 0);
        idle(1);
        check("drop_saturate", drop_count, 255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
